// File: rtl/layer_output_serializer_if.sv
// Bundle between a neuron layer's parallel outputs and the serialized word stream
// that feeds the next layer. The serializer sits on the master side.
interface layer_output_serializer_if #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
);
    logic [numNeurons*dataWidth-1:0] in_data;
    logic [numNeurons-1:0]           in_valid;
    logic                            out_ready;
    logic [dataWidth-1:0]            out_data;
    logic                            out_valid;
    logic                            out_last;
    logic                            busy;
    logic                            overrun;
    logic                            sync_err;

    modport master (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, out_last, busy, overrun, sync_err
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, out_last, busy, overrun, sync_err
    );
endinterface

// File: rtl/layer_output_serializer.sv
// Turns one parallel vector of neuron outputs into a word stream, index 0 first,
// with one pending vector slot so a following capture can stream without a bubble.
module layer_output_serializer #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    layer_output_serializer_if.master   bus
);
    localparam int             IW       = $clog2(numNeurons);
    localparam logic [IW-1:0]  LAST_IDX = IW'(numNeurons - 1);
    localparam logic [0:0]     IDLE     = 1'b0;
    localparam logic [0:0]     SHIFT    = 1'b1;

    logic [0:0]           r_state;
    logic [IW-1:0]        r_idx;
    logic                 r_pending_full;
    logic                 r_out_valid;
    logic                 r_out_last;
    logic                 r_overrun;
    logic                 r_sync_err;
    logic [dataWidth-1:0] r_out_data;
    logic [dataWidth-1:0] r_active  [numNeurons];
    logic [dataWidth-1:0] r_pending [numNeurons];

    logic [dataWidth-1:0] w_vec [numNeurons];
    logic                 w_capture;
    logic                 w_mixed;
    logic                 w_xfer;
    logic                 w_last_xfer;
    logic                 w_load_active_vec;
    logic                 w_load_active_pend;
    logic                 w_load_pend;
    logic                 w_drop;
    logic [IW-1:0]        w_idx_inc;

    always_comb begin
        for (int i = 0; i < numNeurons; i++) begin
            w_vec[i] = bus.in_data[i*dataWidth +: dataWidth];
        end
    end

    // Only neuron 0 keys the capture; disagreement among the other bits is flagged, not acted on.
    assign w_capture   = bus.in_valid[0];
    assign w_mixed     = (bus.in_valid != '0) && (bus.in_valid != '1);
    assign w_xfer      = r_out_valid & bus.out_ready;
    assign w_last_xfer = w_xfer && (r_idx == LAST_IDX);
    assign w_idx_inc   = r_idx + 1'b1;

    assign w_load_active_vec  = w_capture && ((r_state == IDLE) || (w_last_xfer && !r_pending_full));
    assign w_load_active_pend = w_last_xfer && r_pending_full;
    assign w_load_pend        = w_capture && (r_state == SHIFT) &&
                                (w_last_xfer ? r_pending_full : !r_pending_full);
    assign w_drop             = w_capture && (r_state == SHIFT) && !w_last_xfer && r_pending_full;

    // NOTE: vector buffers carry no reset; the flags below decide whether their contents mean anything.
    always_ff @(posedge clk) begin
        for (int i = 0; i < numNeurons; i++) begin
            if (w_load_active_vec) begin
                r_active[i] <= w_vec[i];
            end else if (w_load_active_pend) begin
                r_active[i] <= r_pending[i];
            end
            if (w_load_pend) begin
                r_pending[i] <= w_vec[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_pending_full <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_out_data     <= '0;
            r_overrun      <= 1'b0;
            r_sync_err     <= 1'b0;
        end else begin
            if (w_mixed) r_sync_err <= 1'b1;
            if (w_drop)  r_overrun  <= 1'b1;

            if (w_load_pend) begin
                r_pending_full <= 1'b1;
            end else if (w_load_active_pend) begin
                r_pending_full <= 1'b0;
            end

            // Output word is looked up one cycle ahead so out_data leaves a flop.
            if (w_load_active_vec) begin
                r_out_data <= w_vec[0];
            end else if (w_load_active_pend) begin
                r_out_data <= r_pending[0];
            end else if (w_xfer && !w_last_xfer) begin
                r_out_data <= r_active[w_idx_inc];
            end

            if (w_load_active_vec || w_load_active_pend) begin
                r_state     <= SHIFT;
                r_idx       <= '0;
                r_out_valid <= 1'b1;
                r_out_last  <= 1'b0;
            end else if (w_last_xfer) begin
                r_state     <= IDLE;
                r_idx       <= '0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else if (w_xfer) begin
                r_idx       <= w_idx_inc;
                r_out_last  <= (w_idx_inc == LAST_IDX);
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = (r_state == SHIFT) | r_pending_full;
    assign bus.overrun   = r_overrun;
    assign bus.sync_err  = r_sync_err;
endmodule

// File: doc/layer_output_serializer.md
LAYER_OUTPUT_SERIALIZER -- requirements
Module: layer_output_serializer

Interface
REQ-001 SHALL have parameter numNeurons, default 30, number of neuron outputs per layer (legal range ≥2).
REQ-002 SHALL have parameter dataWidth, default 16, width of each neuron output word.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_data, input, numNeurons*dataWidth, neuron outputs; neuron i occupies bits [i*dataWidth +: dataWidth].
REQ-006 SHALL have port in_valid, input, numNeurons, per-neuron outvalid pulses.
REQ-007 SHALL have port out_ready, input, 1, downstream accept; tied high when feeding a neuron layer.
REQ-008 SHALL have port out_data, output, dataWidth, serialized word, drives the next layer's myinput.
REQ-009 SHALL have port out_valid, output, 1, word valid, drives the next layer's myinputValid.
REQ-010 SHALL have port out_last, output, 1, high with the word of index numNeurons-1.
REQ-011 SHALL have port busy, output, 1, high while a vector is active or pending.
REQ-012 SHALL have port overrun, output, 1, sticky: a captured vector was dropped.
REQ-013 SHALL have port sync_err, output, 1, sticky: in_valid bits disagreed in some cycle.

Function
REQ-014 Capture event = in_valid[0] high; the full in_data vector is latched on that edge.
REQ-015 Any cycle with in_valid neither all-zero nor all-one SHALL set sync_err; capture still keys on in_valid[0] only.
REQ-016 Storage: one active buffer plus one pending buffer, each numNeurons words; pending_full flag.
REQ-017 FSM states IDLE and SHIFT; IDLE: out_valid=0; SHIFT: out_valid=1, out_data=active[idx], all outputs registered.
REQ-018 IDLE + capture -> load active, idx=0, go SHIFT; out_valid high the cycle after in_valid[0] (latency 1).
REQ-019 Transfer = out_valid & out_ready; on transfer idx increments; no transfer -> out_data, idx held stable.
REQ-020 out_last = (idx == numNeurons-1) while in SHIFT.
REQ-021 Last transfer, pending empty, no capture -> IDLE, out_valid low next cycle.
REQ-022 Last transfer, pending full -> pending moves to active, idx=0, stay SHIFT, no bubble cycle.
REQ-023 Last transfer with simultaneous capture, pending empty -> new vector loads active directly, idx=0, stay SHIFT.
REQ-024 Last transfer with simultaneous capture, pending full -> pending to active, new vector to pending, no overrun.
REQ-025 Capture in SHIFT (not last transfer), pending empty -> load pending, pending_full=1.
REQ-026 Capture in SHIFT (not last transfer), pending full -> new vector dropped, overrun set, active and pending unchanged.
REQ-027 Output order SHALL be index 0 first through numNeurons-1; data words passed unmodified (no arithmetic, no width change).
REQ-028 idx width = clog2(numNeurons); idx never exceeds numNeurons-1.
REQ-029 busy = (state==SHIFT) | pending_full.

Reset
REQ-030 rst high SHALL immediately (asynchronously) force state IDLE, idx=0, pending_full=0, out_valid=0, out_last=0, out_data=0, busy=0, overrun=0, sync_err=0.
REQ-031 Reset mid-burst SHALL discard active and pending vectors; no further words emitted until a new capture.
REQ-032 Buffer contents need not reset; only flags and outputs above.
REQ-033 overrun and sync_err SHALL clear only on rst.

Verification (numNeurons=4, dataWidth=16)
REQ-034 in_valid=4'hF one cycle, in_data words {0x0004,0x0003,0x0002,0x0001} (idx3..0), out_ready=1 -> next 4 cycles out_data 0x0001,0x0002,0x0003,0x0004, out_last only on 0x0004, then out_valid=0.
REQ-035 Same vector, out_ready low on 2nd and 3rd beat -> 0x0002 held 3 cycles, total 6 valid cycles, order unchanged.
REQ-036 Second capture 2 cycles after first, third capture 1 cycle later -> first and second vectors emitted back-to-back (8 contiguous valid cycles), third dropped, overrun=1, busy low after.
REQ-037 Capture coincident with last beat of a burst -> next cycle out_data = new word 0 with out_valid continuous, overrun=0.
REQ-038 in_valid=4'b0101 one cycle -> sync_err=1, vector captured and serialized; sync_err stays 1 until rst.
REQ-039 rst asserted mid-burst after beat 1 (async, between edges) -> out_valid, busy, out_last drop immediately; no words after release until next capture.
